// File: rtl/ifetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives the 1-cycle-latency imem
// and hands {pc, instr} to IF/ID through a 2-entry valid/ready buffer.
module ifetch_stage #(
  parameter int                XLEN          = 64,
  parameter int                IM_DEPTH      = 2048,
  parameter int                IM_ADDR_WIDTH = $clog2(IM_DEPTH),
  parameter int                IM_DATA_WIDTH = 32,
  parameter logic [XLEN-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [IM_ADDR_WIDTH-1:0] o_im_addr,
  input  logic [IM_DATA_WIDTH-1:0] i_im_rdata,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [IM_DATA_WIDTH-1:0] o_instr,
  output logic [XLEN-1:0]          o_pc,
  output logic                     o_misaligned
);

  logic [XLEN-1:0]          pc_q;
  logic [XLEN-1:0]          inflight_pc;
  logic                     inflight;
  logic [1:0]               count;
  logic [XLEN-1:0]          buf_pc    [2];
  logic [IM_DATA_WIDTH-1:0] buf_instr [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign pop  = o_valid & i_ready;
  assign push = inflight & ~i_redirect;

  // Credit rule: buffered + in flight after this cycle's pop must leave room for one more.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = ~i_redirect & (occupancy < 3'd2);

  assign o_im_addr    = pc_q[IM_ADDR_WIDTH+1:2];
  assign o_valid      = (count != 2'd0);
  assign o_instr      = buf_instr[0];
  assign o_pc         = buf_pc[0];
  assign o_misaligned = |buf_pc[0][1:0];

  // NOTE: sequential state is written with non-blocking (<=) so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (i_redirect) begin
      pc_q     <= i_redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
      pc_q        <= pc_q + XLEN'(4);
    end else begin
      inflight <= 1'b0;
    end
  end

  // Shift-style FIFO: slot 0 is always the head, so outputs come straight from flops.
  // NOTE: the two buffer slots are reset because slot 0 drives the outputs,
  // which must read zero out of reset; a larger storage array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (i_redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          buf_pc[count[0]]    <= inflight_pc;
          buf_instr[count[0]] <= i_im_rdata;
          count               <= count + 2'd1;
        end
        2'b01: begin
          buf_pc[0]    <= buf_pc[1];
          buf_instr[0] <= buf_instr[1];
          count        <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf_pc[0]    <= inflight_pc;
            buf_instr[0] <= i_im_rdata;
          end else begin
            buf_pc[0]    <= buf_pc[1];
            buf_instr[0] <= buf_instr[1];
            buf_pc[1]    <= inflight_pc;
            buf_instr[1] <= i_im_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a vector table per cycle plus an async-reset sequence.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Synchronous imem model: word k holds 0x1000 + k.
  always @(posedge clk) im_rdata <= 32'h1000 + {21'b0, im_addr};

  ifetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_im_addr    (im_addr),
    .i_im_rdata   (im_rdata),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_instr      (instr),
    .o_pc         (pc),
    .o_misaligned (misaligned)
  );

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic [31:0] ei;
    logic        em;
    logic        ca;
    logic [10:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic redir, input logic [63:0] rpc, input logic rdy,
                     input logic ev, input logic [63:0] epc, input logic [31:0] ei,
                     input logic em, input logic ca, input logic [10:0] ea);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.ei = ei; v.em = em; v.ca = ca; v.ea = ea;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive inputs, check the registered outputs, advance one cycle.
  task automatic apply_row(input int idx);
    vec_t v;
    v = vecs[idx];
    redirect    = v.redir;
    redirect_pc = v.rpc;
    ready       = v.rdy;
    #1;
    check($sformatf("row%0d valid", idx), {63'b0, valid}, {63'b0, v.ev});
    if (v.ev) begin
      check($sformatf("row%0d pc", idx), pc, v.epc);
      check($sformatf("row%0d instr", idx), {32'b0, instr}, {32'b0, v.ei});
      check($sformatf("row%0d misaligned", idx), {63'b0, misaligned}, {63'b0, v.em});
    end
    if (v.ca) check($sformatf("row%0d im_addr", idx), {53'b0, im_addr}, {53'b0, v.ea});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //   redir rpc                     rdy ev  epc                      instr     mis ca  addr
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h000); // 0 reset state
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h001); // 1
    add(0, 64'h0,                   1, 1, 64'h0,                   32'h1000, 0, 0, 11'h0);   // 2 first head
    add(0, 64'h0,                   1, 1, 64'h4,                   32'h1001, 0, 0, 11'h0);   // 3
    add(0, 64'h0,                   0, 1, 64'h8,                   32'h1002, 0, 0, 11'h0);   // 4 stall
    add(0, 64'h0,                   0, 1, 64'h8,                   32'h1002, 0, 1, 11'h004); // 5 pc holds
    add(0, 64'h0,                   0, 1, 64'h8,                   32'h1002, 0, 0, 11'h0);   // 6
    add(0, 64'h0,                   0, 1, 64'h8,                   32'h1002, 0, 0, 11'h0);   // 7
    add(0, 64'h0,                   0, 1, 64'h8,                   32'h1002, 0, 1, 11'h004); // 8
    add(0, 64'h0,                   1, 1, 64'h8,                   32'h1002, 0, 0, 11'h0);   // 9 release
    add(0, 64'h0,                   1, 1, 64'hC,                   32'h1003, 0, 0, 11'h0);   // 10
    add(0, 64'h0,                   1, 1, 64'h10,                  32'h1004, 0, 0, 11'h0);   // 11
    add(0, 64'h0,                   1, 1, 64'h14,                  32'h1005, 0, 0, 11'h0);   // 12
    add(0, 64'h0,                   0, 1, 64'h18,                  32'h1006, 0, 0, 11'h0);   // 13 fill to 2
    add(1, 64'h200,                 0, 1, 64'h18,                  32'h1006, 0, 0, 11'h0);   // 14 redirect
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h080); // 15
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 0, 11'h0);   // 16
    add(0, 64'h0,                   1, 1, 64'h200,                 32'h1080, 0, 0, 11'h0);   // 17 t+3
    add(0, 64'h0,                   1, 1, 64'h204,                 32'h1081, 0, 0, 11'h0);   // 18
    add(1, 64'h300,                 1, 1, 64'h208,                 32'h1082, 0, 0, 11'h0);   // 19 redir+hs
    add(1, 64'h40,                  1, 0, 64'h0,                   32'h0,    0, 0, 11'h0);   // 20 redir again
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h010); // 21
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 0, 11'h0);   // 22
    add(0, 64'h0,                   1, 1, 64'h40,                  32'h1010, 0, 0, 11'h0);   // 23
    add(0, 64'h0,                   1, 1, 64'h44,                  32'h1011, 0, 0, 11'h0);   // 24
    add(1, 64'h102,                 1, 1, 64'h48,                  32'h1012, 0, 0, 11'h0);   // 25 misaligned
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h040); // 26
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h041); // 27
    add(0, 64'h0,                   1, 1, 64'h102,                 32'h1040, 1, 0, 11'h0);   // 28
    add(0, 64'h0,                   1, 1, 64'h106,                 32'h1041, 1, 0, 11'h0);   // 29
    add(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 64'h10A,                 32'h1042, 1, 0, 11'h0);   // 30 wrap
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h7FF); // 31
    add(0, 64'h0,                   1, 0, 64'h0,                   32'h0,    0, 1, 11'h000); // 32
    add(0, 64'h0,                   1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h17FF, 0, 0, 11'h0);   // 33
    add(0, 64'h0,                   1, 1, 64'h0,                   32'h1000, 0, 0, 11'h0);   // 34
    add(0, 64'h0,                   1, 1, 64'h4,                   32'h1001, 0, 0, 11'h0);   // 35

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready       = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) apply_row(i);

    // Asynchronous reset between edges while a stream is active.
    redirect = 1'b0;
    ready    = 1'b1;
    @(posedge clk);
    #2;
    check("pre-reset valid", {63'b0, valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("async reset valid", {63'b0, valid}, 64'h0);
    check("async reset pc", pc, 64'h0);
    check("async reset instr", {32'b0, instr}, 64'h0);
    check("async reset im_addr", {53'b0, im_addr}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply_row(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
